// File: rtl/falafel_pkg.sv
// falafel_pkg: shared types and constants for the falafel allocator's memory
// path.
//   DATA_W          - word and address width in bits.
//   mem_op_t        - decoded request operation.
//   mem_rsp_state_t - responder FSM state encoding.
//   decode_op()     - maps the (is_write, is_cas) request flags to mem_op_t.
package falafel_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_CAS   = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } mem_rsp_state_t;

  // is_cas only qualifies a write; on a read it is ignored.
  function automatic mem_op_t decode_op(input logic is_write, input logic is_cas);
    if (!is_write) return MEM_READ;
    if (is_cas)    return MEM_CAS;
    return MEM_WRITE;
  endfunction

endpackage

// File: rtl/falafel_mem_array.sv
// falafel_mem_array: single-port word storage with a combinational read and a
// synchronous write.
//   clk   in  1          - clock
//   we    in  1          - write enable, commits wdata to mem[idx] at the edge
//   idx   in  IDX_W      - word index (shared by the read and the write)
//   wdata in  DATA_W     - write data
//   rdata out DATA_W     - current contents of mem[idx]
// Contents are not reset.
module falafel_mem_array #(
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/falafel_mem_responder.sv
// falafel_mem_responder: memory-side endpoint for the falafel request/response
// interface. Executes read, write and compare-and-swap atomically at the
// acceptance edge and returns one response per request after LATENCY extra
// cycles. One request outstanding at a time.
//   clk_i / rst_ni        - clock, synchronous active-low reset
//   mem_req_val_i/rdy_o   - request handshake
//   mem_req_is_write_i    - 1 = write or CAS, 0 = read
//   mem_req_is_cas_i      - with is_write: 1 = CAS, 0 = plain write
//   mem_req_addr_i        - byte address (low offset bits ignored, high bits alias)
//   mem_req_data_i        - write data / CAS new value
//   mem_req_cas_exp_i     - CAS expected value
//   mem_rsp_val_o/rdy_i   - response handshake
//   mem_rsp_data_o        - read data, write ack (= data), or CAS old value
module falafel_mem_responder
  import falafel_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  input  logic [DATA_W-1:0] mem_req_cas_exp_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  localparam logic [1:0] ST_IDLE = RSP_IDLE;
  localparam logic [1:0] ST_WAIT = RSP_WAIT;
  localparam logic [1:0] ST_RESP = RSP_RESP;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req_rdy;
  logic              rsp_val;
  logic [DATA_W-1:0] rsp_data;

  logic              accept;
  mem_op_t           op;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              we;
  logic [DATA_W-1:0] op_result;
  logic              unused_addr_bits;

  // Byte-offset bits and bits above the array index are deliberately dropped;
  // out-of-range addresses alias into the array.
  assign idx              = mem_req_addr_i[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{mem_req_addr_i[OFF_W-1:0],
                              mem_req_addr_i[DATA_W-1:OFF_W+IDX_W]};

  // rst_ni gating keeps a request held across a reset edge from touching memory.
  assign accept = mem_req_val_i && req_rdy && rst_ni;
  assign op     = decode_op(mem_req_is_write_i, mem_req_is_cas_i);

  falafel_mem_array #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk   (clk_i),
    .we    (we),
    .idx   (idx),
    .wdata (mem_req_data_i),
    .rdata (rd_word)
  );

  // Compare and write happen against the same combinational read in one edge,
  // which is what makes CAS atomic.
  always_comb begin
    we        = 1'b0;
    op_result = rd_word;
    case (op)
      MEM_WRITE: begin
        we        = accept;
        op_result = mem_req_data_i;
      end
      MEM_CAS: begin
        we        = accept && (rd_word == mem_req_cas_exp_i);
        op_result = rd_word;
      end
      default: begin
        we        = 1'b0;
        op_result = rd_word;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        // Spends exactly LATENCY cycles here before the response goes valid.
        if (cnt <= CNT_W'(1)) state_nxt = ST_RESP;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_RESP: begin
        if (mem_rsp_rdy_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ready and valid are registered from the next state so neither has a
  // combinational path from the request or response inputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req_rdy  <= 1'b0;
      rsp_val  <= 1'b0;
      rsp_data <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      req_rdy <= (state_nxt == ST_IDLE);
      rsp_val <= (state_nxt == ST_RESP);
      if (accept) rsp_data <= op_result;
    end
  end

  assign mem_req_rdy_o  = req_rdy;
  assign mem_rsp_val_o  = rsp_val;
  assign mem_rsp_data_o = rsp_data;

endmodule

// File: doc/falafel_mem_responder.md
# falafel_mem_responder

Synthesizable memory-side responder for the falafel allocator's memory request/response interface. It accepts the read, write and compare-and-swap requests issued on `mem_req_*` and executes them atomically against an internal word array. It returns exactly one response per request on `mem_rsp_*` after a configurable latency. It is the memory endpoint for falafel in simulation and FPGA bring-up, and serves as the reference model for the LSU's memory protocol.

## Interface
- `DATA_W`, from `falafel_pkg`: word and address width.
- `MEM_WORDS`, default 1024: array depth in words; power of two.
- `LATENCY`, default 2: extra cycles between acceptance and response valid; 0 or more.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `mem_req_val_i` in 1: request valid.
- `mem_req_rdy_o` out 1: responder ready to accept a request.
- `mem_req_is_write_i` in 1: 1 = write or CAS, 0 = read.
- `mem_req_is_cas_i` in 1: qualifies a write; 1 = CAS, 0 = plain write.
- `mem_req_addr_i` in DATA_W: byte address.
- `mem_req_data_i` in DATA_W: write data, or CAS new value.
- `mem_req_cas_exp_i` in DATA_W: CAS expected value.
- `mem_rsp_val_o` out 1: response valid.
- `mem_rsp_rdy_i` in 1: requester ready for the response.
- `mem_rsp_data_o` out DATA_W: response data.

## Operation
- Operation decode:
  - `is_write=0`: read; `is_cas` is ignored.
  - `is_write=1, is_cas=0`: plain write.
  - `is_write=1, is_cas=1`: CAS.
- Word index is `addr[$clog2(DATA_W/8) +: $clog2(MEM_WORDS)]`.
  - Low byte-offset bits are ignored.
  - Upper bits are truncated, so out-of-range addresses alias into the array; this is not an error.
- Execution happens at the acceptance edge (`val_i && rdy_o`). The whole read-modify-write is a single edge, so CAS is atomic by construction.
- Response data by operation:
  - Read: returns `mem[idx]`.
  - Plain write: `mem[idx] <= data`; returns `data` as the acknowledgement.
  - CAS: if `mem[idx] == cas_exp`, then `mem[idx] <= data`; otherwise memory is unchanged. It always returns the old `mem[idx]`. The requester determines success by comparing the returned value with `cas_exp`.
- Only one request is outstanding at a time. There is no pipelining and no queue.
- FSM states:
  - IDLE: `rdy_o=1`. On acceptance, go to WAIT with the counter set to `LATENCY`. If `LATENCY==0`, go directly to RESP.
  - WAIT: decrement the counter; go to RESP when the counter reaches 1.
  - RESP: `rsp_val_o=1`. Go to IDLE on `rsp_rdy_i`.
- Response data is captured at acceptance and held stable throughout RESP.
- Array contents are not reset.

## Timing
- Reset values: `mem_req_rdy_o=0` during reset and 1 in the first cycle after reset; `mem_rsp_val_o=0`; `mem_rsp_data_o=0`; FSM in IDLE.
- Latency: a request accepted at edge T has its response valid in cycle T+1+LATENCY. The earliest next acceptance is the edge after the response handshake.
- `mem_req_rdy_o` does not depend combinationally on `mem_req_val_i`.
- `mem_rsp_val_o` and `mem_rsp_data_o` are registered.
- Backpressure: while `rsp_rdy_i=0`, `rsp_val_o` and the data stay asserted and stable indefinitely, and `req_rdy_o` stays 0.
- Simultaneous events: the response handshake and a new request in the same cycle are not both taken. The new request is accepted no earlier than the following cycle, in IDLE.
- Back-to-back requests to the same word observe each other's writes in order.
- Reset mid-operation: a pending response is dropped and no response is ever issued for it. An array update already committed at acceptance persists.

## Structure
- `falafel_pkg` additions:
  - `mem_op_t` enum {MEM_READ, MEM_WRITE, MEM_CAS}.
  - `mem_rsp_state_t` enum {RSP_IDLE, RSP_WAIT, RSP_RESP}.
  - Reuse the existing `DATA_W`.
- Sub-module `falafel_mem_array`: single-port synchronous word array with a combinational read and a write enable. It holds the storage only; the CAS compare lives in the responder.

## Test plan
- Read after write, LATENCY=2:
  - Write 0xDEAD_BEEF to 0x40 → write response 0xDEAD_BEEF.
  - Then read 0x40 → 0xDEAD_BEEF, valid exactly 3 cycles after acceptance.
- CAS success and failure:
  - mem[0x80]=5; CAS exp=5, new=9 → response 5; a read returns 9.
  - Then CAS exp=5, new=7 → response 9; a read still returns 9.
- Backpressure:
  - Hold `rsp_rdy_i=0` for 10 cycles → `rsp_val_o` and data stay stable, `req_rdy_o=0` throughout.
  - Release → handshake, and `req_rdy_o=1` the next cycle.
- LATENCY=0, back-to-back:
  - Write 1, 2, 3 to 0x0, 0x8, 0x10, then read all three → responses 1, 2, 3, 1, 2, 3, each valid one cycle after its acceptance.
- Aliasing: with MEM_WORDS=1024 and 8-byte words, write 0xA to 0x2000 → reading 0x0 returns 0xA, and reading 0x2003 returns 0xA.
- Reset mid-WAIT:
  - Accept a write of 0x55 to 0x18, then pulse `rst_ni` low before the response → no response appears.
  - After reset, reading 0x18 returns 0x55.
